call_stack: RTL and testbench
=============================

Name: call_stack

Overview:
- Hardware return-address stack for the 19-bit pipelined CPU; consumes the ID-stage push, pop and ret strobes produced by the control decoder for CALL/RET.
- On CALL, stores the return address (PC+1) supplied by the fetch/decode datapath.
- On RET, presents the top entry to the PC-select mux in the same cycle, then discards it at the clock edge.
- Detects and flags overflow and underflow.

Parameters:
- ADDR_W, 19, width of a stored return address (CPU address width).
- DEPTH, 16, number of stack entries; power of two, at least 2.
- SP_W, $clog2(DEPTH)+1, stack-pointer width; holds 0..DEPTH inclusive.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  pipeline advance; push and pop are ignored when en=0 (ID stall).
- push  input  1  ID_push from the control decoder (CALL).
- pop  input  1  ID_pop from the control decoder (RET).
- push_addr  input  ADDR_W  return address to store on push.
- err_clr  input  1  synchronous clear of the sticky error flags.
- ret_addr  output  ADDR_W  current top-of-stack entry; combinational from the registered state.
- sp  output  SP_W  number of valid entries.
- empty  output  1  sp==0.
- full  output  1  sp==DEPTH.
- overflow  output  1  sticky flag: a push was dropped because the stack was full.
- underflow  output  1  sticky flag: a pop was attempted while the stack was empty.

Behaviour:
- Reset (async, rst_n=0):
  - sp=0; all DEPTH entries=0; overflow=0; underflow=0.
  - Outputs: ret_addr=0, empty=1, full=0.
  - Reset takes effect immediately regardless of clk. Any push or pop in that cycle is lost.
- Storage: DEPTH x ADDR_W register array. Entry k is valid when k<sp. The top entry is mem[sp-1].
- ret_addr:
  - Equals mem[sp-1] when sp>0, otherwise 0.
  - Zero latency: a RET in ID sees the address in the same cycle as the pop strobe.
  - A push at edge N is visible on ret_addr after edge N.
- Effective strobes: push_e = push & en; pop_e = pop & en.
- Per rising edge, evaluated in priority order:
  - push_e & pop_e & sp>0: mem[sp-1] <= push_addr; sp unchanged (replace top).
  - push_e & pop_e & sp==0: behaves as a push; underflow <= 1.
  - push_e only, sp<DEPTH: mem[sp] <= push_addr; sp <= sp+1.
  - push_e only, sp==DEPTH: no write; sp unchanged; overflow <= 1. The existing contents are preserved, with no wrap-around or overwrite of the oldest entry.
  - pop_e only, sp>0: sp <= sp-1. The entry contents are left as-is (stale, invalid).
  - pop_e only, sp==0: sp unchanged; underflow <= 1.
  - Neither strobe: hold.
- Error flags:
  - Once set, a flag stays set until err_clr=1 at an edge, or reset.
  - If err_clr is asserted in the same edge as a new error event, the flag ends set (set wins).
- en=0 blocks all stack updates; err_clr is still honoured.
- full and empty are pure decodes of sp. They are never both 1.
- No bypass of push_addr to ret_addr within a cycle.

Decomposition:
- ADDR_W and DEPTH defaults go in parameter.v as `ADDR_W / `STACK_DEPTH, beside the opcode defines, so the control decoder, PC logic and call_stack share them.
- No sub-module; the storage array, sp counter and flag logic are inline. Target size is about 120-160 lines.

Test Plan:
- Reset, then idle -> sp=0, empty=1, full=0, ret_addr=0, overflow=0, underflow=0; assert rst_n low mid-cycle after 3 pushes -> sp=0 and ret_addr=0 immediately, without waiting for an edge.
- Push 0x00010, 0x00020, 0x7FFFF on consecutive cycles -> ret_addr=0x7FFFF, sp=3; three pops -> ret_addr reads 0x7FFFF, 0x00020, 0x00010 in the pop cycles; then empty=1 and ret_addr=0.
- Push 17 distinct values 0x00001..0x00011 with DEPTH=16 -> full=1, sp=16, overflow=1, ret_addr=0x00010; 16 pops return 0x00010..0x00001 in order.
- Pop on an empty stack -> sp stays 0, underflow=1; err_clr=1 for one cycle -> underflow=0; err_clr together with another empty pop -> underflow stays 1.
- With sp=2 and top=0x00123, push=pop=1 with push_addr=0x00456 -> sp=2, ret_addr=0x00456, entry 0 unchanged.
- en=0 while push=1 or pop=1 -> sp, contents and flags unchanged for all 4 combinations of push and pop.

Source files
------------

// File: rtl/call_stack_pkg.sv
// call_stack_pkg: shared widths and op encoding for the return-address stack.
package call_stack_pkg;
    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DEPTH  = 16;
    typedef enum logic [1:0] {OP_HOLD, OP_PUSH, OP_POP, OP_REPLACE} stack_op_e;
endpackage

// File: rtl/call_stack.sv
// call_stack: return-address stack with zero-latency top read and sticky
// overflow/underflow flags.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SP_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] ret_addr,
    output logic [SP_W-1:0]   sp,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam int IDX_W = $clog2(DEPTH);
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp_m1;
    logic [IDX_W-1:0]  top_idx;
    logic              push_e, pop_e, ovf_evt, unf_evt;
    stack_op_e         op;
    assign push_e   = push & en;
    assign pop_e    = pop & en;
    assign empty    = sp == '0;
    assign full     = sp == SP_W'(DEPTH);
    assign sp_m1    = sp - SP_W'(1);
    assign top_idx  = sp_m1[IDX_W-1:0];
    assign ret_addr = empty ? '0 : mem[top_idx];
    assign ovf_evt  = push_e & ~pop_e & full;
    assign unf_evt  = pop_e & empty;
    // A simultaneous push/pop on an empty stack degrades to a plain push.
    always_comb begin
        op = (push_e & pop_e & ~empty) ? OP_REPLACE :
             (push_e & ~full)          ? OP_PUSH :
             (pop_e & ~push_e & ~empty) ? OP_POP : OP_HOLD;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (op)
                OP_REPLACE: mem[top_idx] <= push_addr;
                OP_PUSH: begin
                    mem[sp[IDX_W-1:0]] <= push_addr;
                    sp <= sp + SP_W'(1);
                end
                OP_POP:  sp <= sp_m1;
                default: ;
            endcase
            overflow  <= ovf_evt | (overflow & ~err_clr);
            underflow <= unf_evt | (underflow & ~err_clr);
        end
    end
endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: directed checks of push/pop ordering, bounds, flags and stalls.
module tb_call_stack;
    logic        clk = 1'b0;
    logic        rst_n, en, push, pop, err_clr;
    logic [18:0] push_addr, ret_addr;
    logic [4:0]  sp;
    logic        empty, full, overflow, underflow;
    int          n_cmp = 0;
    int          n_err = 0;

    call_stack dut (
        .clk(clk), .rst_n(rst_n), .en(en), .push(push), .pop(pop),
        .push_addr(push_addr), .err_clr(err_clr), .ret_addr(ret_addr),
        .sp(sp), .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic q, input logic [18:0] a, input logic c = 1'b0);
        push = p; pop = q; push_addr = a; err_clr = c;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [18:0] exp);
        pop = 1'b1;
        #1 chk(tag, 32'(ret_addr), 32'(exp));
        @(posedge clk); #1;
        pop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; push = 1'b0; pop = 1'b0; push_addr = '0; err_clr = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_sp", 32'(sp), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ret", 32'(ret_addr), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        cyc(1, 0, 19'h00010);
        cyc(1, 0, 19'h00020);
        cyc(1, 0, 19'h7FFFF);
        chk("p3_ret", 32'(ret_addr), 32'h7FFFF);
        chk("p3_sp", 32'(sp), 3);
        pop_chk("pop0", 19'h7FFFF);
        pop_chk("pop1", 19'h00020);
        pop_chk("pop2", 19'h00010);
        chk("p3_empty", 32'(empty), 1);
        chk("p3_ret0", 32'(ret_addr), 0);

        for (int i = 1; i <= 17; i++) cyc(1, 0, 19'(i));
        chk("fill_full", 32'(full), 1);
        chk("fill_sp", 32'(sp), 16);
        chk("fill_ovf", 32'(overflow), 1);
        chk("fill_ret", 32'(ret_addr), 32'h10);
        chk("fill_empty", 32'(empty), 0);
        for (int i = 16; i >= 1; i--) pop_chk($sformatf("drain%0d", i), 19'(i));
        chk("drain_empty", 32'(empty), 1);
        chk("ovf_sticky", 32'(overflow), 1);
        cyc(0, 0, '0, 1'b1);
        chk("ovf_clr", 32'(overflow), 0);

        cyc(0, 1, '0);
        chk("unf_sp", 32'(sp), 0);
        chk("unf_set", 32'(underflow), 1);
        cyc(0, 0, '0, 1'b1);
        chk("unf_clr", 32'(underflow), 0);
        cyc(0, 1, '0, 1'b1);
        chk("unf_setwins", 32'(underflow), 1);
        cyc(0, 0, '0, 1'b1);

        cyc(1, 1, 19'h00005);
        chk("pp_empty_sp", 32'(sp), 1);
        chk("pp_empty_ret", 32'(ret_addr), 5);
        chk("pp_empty_unf", 32'(underflow), 1);
        cyc(0, 0, '0, 1'b1);
        cyc(0, 1, '0);

        cyc(1, 0, 19'h00111);
        cyc(1, 0, 19'h00123);
        cyc(1, 1, 19'h00456);
        chk("repl_sp", 32'(sp), 2);
        chk("repl_ret", 32'(ret_addr), 32'h456);
        cyc(0, 1, '0);
        chk("repl_entry0", 32'(ret_addr), 32'h111);
        chk("repl_unf", 32'(underflow), 0);

        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(k[0], k[1], 19'h00BBB);
            chk($sformatf("stall%0d_sp", k), 32'(sp), 1);
            chk($sformatf("stall%0d_ret", k), 32'(ret_addr), 32'h111);
            chk($sformatf("stall%0d_flags", k), {30'd0, overflow, underflow}, 0);
        end
        cyc(0, 1, '0);
        chk("stall_pop_sp", 32'(sp), 1);
        en = 1'b1;
        cyc(0, 1, '0);
        cyc(0, 1, '0);
        en = 1'b0;
        cyc(0, 0, '0, 1'b1);
        chk("stall_clr", 32'(underflow), 0);
        en = 1'b1;

        cyc(1, 0, 19'h00AAA);
        cyc(1, 0, 19'h00BBB);
        cyc(1, 0, 19'h00CCC);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_sp", 32'(sp), 0);
        chk("arst_ret", 32'(ret_addr), 0);
        chk("arst_empty", 32'(empty), 1);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_hold", 32'(sp), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
